// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the rate-1/2, K=3 (7,5) code.
// Define VITERBI_ERRCNT_EN to add the err_count output (corrected-symbol-error tally).
module viterbi_decoder #(
  parameter int TB_DEPTH = 15,
  parameter int METRIC_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_sym,
`ifdef VITERBI_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic        out_valid,
  output logic        out_bit
);

  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] PM_MAX = '1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);

  // The oldest survivor bit is only ever read straight off the ACS result,
  // so the stored registers keep TB_DEPTH-1 bits.
  logic [METRIC_W-1:0] pm_q   [4];
  logic [METRIC_W-1:0] pm_d   [4];
  logic [TB_DEPTH-2:0] surv_q [4];
  logic [TB_DEPTH-2:0] surv_d [4];
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic                out_bit_q, out_bit_d;

  logic [METRIC_W-1:0] acsPm   [4];
  logic [TB_DEPTH-1:0] newSurv [4];
  logic [METRIC_W-1:0] minPm;
  logic [1:0]          best;
  logic [FILL_W:0]     fillInc;

`ifdef VITERBI_ERRCNT_EN
  logic [1:0]  bmSel [4];
  logic [15:0] errcnt_q, errcnt_d;
  logic [16:0] errSum;
`endif

  function automatic logic [1:0] branchMetric(input logic [1:0] rx, input logic u,
                                              input logic a, input logic b);
    logic [1:0] diff;
    diff = rx ^ {u ^ a ^ b, u ^ b};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] satAdd(input logic [METRIC_W-1:0] pm,
                                                 input logic [1:0] bm);
    logic [METRIC_W:0] sum;
    sum = {1'b0, pm} + {{(METRIC_W-1){1'b0}}, bm};
    return sum[METRIC_W] ? PM_MAX : sum[METRIC_W-1:0];
  endfunction

  // Add-compare-select: new state {u,a} chooses between predecessors {a,0} and {a,1}.
  always_comb begin
    logic [1:0]          nsIdx;
    logic                u, a, sel;
    logic [1:0]          bm0, bm1;
    logic [METRIC_W-1:0] c0, c1;
    nsIdx = '0;
    u = 1'b0;
    a = 1'b0;
    sel = 1'b0;
    bm0 = '0;
    bm1 = '0;
    c0 = '0;
    c1 = '0;
    for (int ns = 0; ns < 4; ns++) begin
      nsIdx = 2'(ns);
      u = nsIdx[1];
      a = nsIdx[0];
      bm0 = branchMetric(in_sym, u, a, 1'b0);
      bm1 = branchMetric(in_sym, u, a, 1'b1);
      c0 = satAdd(pm_q[{a, 1'b0}], bm0);
      c1 = satAdd(pm_q[{a, 1'b1}], bm1);
      sel = (c1 < c0);
      acsPm[ns] = sel ? c1 : c0;
      newSurv[ns] = {surv_q[{a, sel}], u};
`ifdef VITERBI_ERRCNT_EN
      bmSel[ns] = sel ? bm1 : bm0;
`endif
    end
  end

  always_comb begin
    minPm = acsPm[0];
    best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acsPm[i] < minPm) begin
        minPm = acsPm[i];
        best = 2'(i);
      end
    end
  end

  // Next-state: everything holds while idle except the output strobe.
  always_comb begin
    fillInc = {1'b0, fill_q} + (FILL_W+1)'(1);
    for (int i = 0; i < 4; i++) begin
      pm_d[i] = pm_q[i];
      surv_d[i] = surv_q[i];
    end
    fill_d = fill_q;
    out_valid_d = 1'b0;
    out_bit_d = out_bit_q;
    if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        pm_d[i] = acsPm[i] - minPm;
        surv_d[i] = newSurv[i][TB_DEPTH-2:0];
      end
      if (fill_q != FILL_MAX) begin
        fill_d = fillInc[FILL_W-1:0];
      end
      out_valid_d = (fillInc >= (FILL_W+1)'(TB_DEPTH));
      out_bit_d = newSurv[best][TB_DEPTH-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pm_q[0] <= '0;
      for (int i = 1; i < 4; i++) begin
        pm_q[i] <= PM_MAX;
      end
      for (int i = 0; i < 4; i++) begin
        surv_q[i] <= '0;
      end
      fill_q <= '0;
      out_valid_q <= 1'b0;
      out_bit_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      fill_q <= fill_d;
      out_valid_q <= out_valid_d;
      out_bit_q <= out_bit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit = out_bit_q;

`ifdef VITERBI_ERRCNT_EN
  // Tally the branch cost of the transition that landed in the current best state.
  always_comb begin
    errSum = {1'b0, errcnt_q} + {15'b0, bmSel[best]};
    errcnt_d = errcnt_q;
    if (in_valid) begin
      errcnt_d = errSum[16] ? 16'hFFFF : errSum[15:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: a forward-iterating trellis model predicts each decoded bit.
// Directed streams are also checked against hand-derived constants.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 15;
  localparam int METRIC_W = 6;
  localparam int PM_MAX = (1 << METRIC_W) - 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_sym = 2'b00;
  logic       out_valid;
  logic       out_bit;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_count;
`endif

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_sym(in_sym),
`ifdef VITERBI_ERRCNT_EN
    .err_count(err_count),
`endif
    .out_valid(out_valid),
    .out_bit(out_bit)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  bit expQ[$];
  bit gotBits[$];
  int acceptedCount = 0;
  int firstPulseAt = -1;
  int pulseCount = 0;
  bit lastAccepted = 1'b0;

  int mPm[4];
  logic [31:0] mSurv[4];
  int mFill;
  int mErr;

  logic [1:0] stream[20];
  bit dataExp[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    mPm[0] = 0;
    for (int i = 1; i < 4; i++) mPm[i] = PM_MAX;
    for (int i = 0; i < 4; i++) mSurv[i] = '0;
    mFill = 0;
    mErr = 0;
  endfunction

  // Forward trellis walk: every old state s pushes both inputs u into state {u,a}.
  task automatic modelStep(input logic [1:0] sym);
    int newPm[4];
    logic [31:0] newSurv[4];
    int newBm[4];
    int minV;
    int best;
    for (int i = 0; i < 4; i++) begin
      newPm[i] = 1 << 30;
      newSurv[i] = '0;
      newBm[i] = 0;
    end
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        int a, b, ns, bm, cand;
        logic [1:0] expSym, d;
        a = (s >> 1) & 1;
        b = s & 1;
        ns = u * 2 + a;
        expSym = {1'(u ^ a ^ b), 1'(u ^ b)};
        d = sym ^ expSym;
        bm = int'(d[0]) + int'(d[1]);
        cand = mPm[s] + bm;
        if (cand > PM_MAX) cand = PM_MAX;
        if (cand < newPm[ns]) begin
          newPm[ns] = cand;
          newSurv[ns] = (mSurv[s] << 1) | 32'(u);
          newBm[ns] = bm;
        end
      end
    end
    minV = newPm[0];
    best = 0;
    for (int i = 1; i < 4; i++) begin
      if (newPm[i] < minV) begin
        minV = newPm[i];
        best = i;
      end
    end
    for (int i = 0; i < 4; i++) begin
      mPm[i] = newPm[i] - minV;
      mSurv[i] = newSurv[i];
    end
    if (mFill < TB_DEPTH) mFill++;
    if (mFill >= TB_DEPTH) expQ.push_back(newSurv[best][TB_DEPTH-1]);
    mErr = mErr + newBm[best];
    if (mErr > 65535) mErr = 65535;
  endtask

  always @(posedge clock) begin
    lastAccepted = in_valid && !reset;
    if (lastAccepted) acceptedCount++;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        if (firstPulseAt < 0) firstPulseAt = acceptedCount;
        pulseCount++;
        gotBits.push_back(out_bit);
        if (expQ.size() == 0) checkOutput("unexpected_pulse", 32'd1, 32'd0);
        else checkOutput("decoded_bit", 32'(out_bit), 32'(expQ.pop_front()));
      end
      if (!lastAccepted) checkOutput("idle_valid", 32'(out_valid), 32'd0);
    end
  end

  // Leaves the bench just after a falling edge with reset released.
  task automatic resetDut();
    reset = 1'b1;
    in_valid = 1'b0;
    in_sym = 2'b00;
    modelReset();
    expQ.delete();
    gotBits.delete();
    acceptedCount = 0;
    firstPulseAt = -1;
    pulseCount = 0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_bit", 32'(out_bit), 32'd0);
`ifdef VITERBI_ERRCNT_EN
    checkOutput("reset_errcnt", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] sym, input int gap);
    in_valid = 1'b1;
    in_sym = sym;
    @(posedge clock);
    modelStep(sym);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic drain();
    repeat (2) @(negedge clock);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkDataStream(input string tag);
    checkOutput({tag, "_count"}, 32'(gotBits.size()), 32'd6);
    for (int i = 0; i < 6 && i < gotBits.size(); i++) begin
      checkOutput({tag, "_bit"}, 32'(gotBits[i]), 32'(dataExp[i]));
    end
  endtask

  task automatic buildStream();
    stream[0] = 2'b11;
    stream[1] = 2'b10;
    stream[2] = 2'b00;
    stream[3] = 2'b01;
    stream[4] = 2'b01;
    stream[5] = 2'b11;
    for (int i = 6; i < 20; i++) stream[i] = 2'b00;
  endtask

  initial begin
    buildStream();
    resetDut();

    // All-zero stream: first pulse after symbol 15, six zero bits.
    for (int i = 0; i < 20; i++) applyStimulus(2'b00, 0);
    drain();
    checkOutput("zero_first_pulse", 32'(firstPulseAt), 32'd15);
    checkOutput("zero_pulses", 32'(pulseCount), 32'd6);
    for (int i = 0; i < gotBits.size(); i++) checkOutput("zero_bit", 32'(gotBits[i]), 32'd0);

    resetDut();
    for (int i = 0; i < 20; i++) applyStimulus(stream[i], 0);
    drain();
    checkDataStream("clean");

    // Single channel error on the third symbol.
    resetDut();
    for (int i = 0; i < 20; i++) applyStimulus((i == 2) ? 2'b10 : stream[i], 0);
    drain();
    checkDataStream("corrupt");
`ifdef VITERBI_ERRCNT_EN
    checkOutput("corrupt_errcnt", 32'(err_count), 32'(mErr));
`endif

    resetDut();
    for (int i = 0; i < 20; i++) applyStimulus(stream[i], $urandom_range(1, 5));
    drain();
    checkDataStream("gapped");

    // Asynchronous reset in the middle of an output pulse.
    resetDut();
    for (int i = 0; i < 16; i++) applyStimulus(stream[i], 0);
    in_valid = 1'b1;
    in_sym = stream[16];
    @(posedge clock);
    #2;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_reset_bit", 32'(out_bit), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_bit", 32'(out_bit), 32'd0);
    resetDut();
    for (int i = 0; i < 20; i++) applyStimulus(stream[i], 0);
    drain();
    checkOutput("replay_first_pulse", 32'(firstPulseAt), 32'd15);
    checkDataStream("replay");

    // Random symbols, mostly back-to-back with occasional idle gaps.
    resetDut();
    for (int i = 0; i < 500; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
    drain();
    checkOutput("random_pulses", 32'(pulseCount), 32'(500 - TB_DEPTH + 1));
`ifdef VITERBI_ERRCNT_EN
    checkOutput("random_errcnt", 32'(err_count), 32'(mErr));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
